uart_word_io: RTL

Core-side sequencer that drives the byte-level UART controller (`uart_unit`) through its `uart_go`/`rors`/`uart_done` handshake. It turns one core I/O request into a transfer of 1 or 4 bytes. A send transfer splits a word into bytes, LSB first. A receive transfer assembles bytes, little-endian, into a 32-bit result. It sits between the core's I/O stage and `uart_unit`, and is the initiator side of that handshake.

---
 rtl/uart_io_pkg.sv | 17 +
 rtl/uart_word_io.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_io_pkg.sv
// Shared types and constants for the UART word sequencer.
// State encoding, transfer-size codes and word width in bytes.
package uart_io_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } uart_io_state_t;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   localparam int NBYTES_WORD = 4;

endpackage

// File: rtl/uart_word_io.sv
// Core-side sequencer: one request becomes 1 or 4 uart_unit byte
// transfers; send splits LSB first, receive assembles little-endian.
import uart_io_pkg::*;

module uart_word_io #(
   parameter int NBYTES_WORD = uart_io_pkg::NBYTES_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_size,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        busy,
   output logic        uart_go,
   output logic        rors,
   output logic [7:0]  txdata,
   input  logic [7:0]  rxdata,
   input  logic        uart_done
);

   localparam int IW = $clog2(NBYTES_WORD);
   localparam logic [IW-1:0] LAST_WORD = IW'(NBYTES_WORD - 1);

   uart_io_state_t state_q, state_d;
   logic           write_q, write_d;
   logic           size_q, size_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [31:0]    asm_q, asm_d;
   logic           uart_go_q, uart_go_d;
   logic           rors_q, rors_d;
   logic [7:0]     txdata_q, txdata_d;
   logic           resp_valid_q, resp_valid_d;
   logic [31:0]    resp_rdata_q, resp_rdata_d;
   logic           busy_q, busy_d;
   logic [IW-1:0]  last_idx;

   assign last_idx   = (size_q == SZ_WORD) ? LAST_WORD : '0;
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign busy       = busy_q;
   assign uart_go    = uart_go_q;
   assign rors       = rors_q;
   assign txdata     = txdata_q;

   // Next state, byte sequencing, and outputs derived from next state
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      wdata_d      = wdata_q;
      idx_d        = idx_q;
      asm_d        = asm_q;
      resp_rdata_d = resp_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               size_d  = req_size;
               wdata_d = req_wdata;
               idx_d   = '0;
               asm_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (uart_done) begin
               if (!write_q) begin
                  asm_d[{idx_q, 3'b000} +: 8] = rxdata;
               end
               if (idx_q == last_idx) begin
                  state_d = RESP;
                  if (!write_q) begin
                     resp_rdata_d = asm_d;
                  end
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      uart_go_d    = (state_d == ISSUE);
      resp_valid_d = (state_d == RESP);
      busy_d       = (state_d != IDLE);
      rors_d       = ((state_d == ISSUE) || (state_d == WAIT)) & write_d;
      txdata_d     = (state_d != IDLE) ? wdata_d[{idx_d, 3'b000} +: 8] : 8'h00;
   end

   // State and registered outputs; reset drops any transfer in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= SZ_BYTE;
         wdata_q      <= '0;
         idx_q        <= '0;
         asm_q        <= '0;
         uart_go_q    <= 1'b0;
         rors_q       <= 1'b0;
         txdata_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         wdata_q      <= wdata_d;
         idx_q        <= idx_d;
         asm_q        <= asm_d;
         uart_go_q    <= uart_go_d;
         rors_q       <= rors_d;
         txdata_q     <= txdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         busy_q       <= busy_d;
      end
   end

endmodule
